// File: rtl/s_mem_pkg.sv
// Shared types and client ids for the RC4 S-memory port arbiter.
// The FSM encoding, client numbering and tag-to-one-hot helper live here.
package s_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} mem_port_state_t;

  typedef logic [1:0] client_id_t;

  localparam client_id_t CLIENT_INIT = 2'd0;
  localparam client_id_t CLIENT_SHUF = 2'd1;
  localparam client_id_t CLIENT_DEC  = 2'd2;
  localparam int         NUM_CLIENTS = 3;

  function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_id_t id);
    return NUM_CLIENTS'(1) << id;
  endfunction

endpackage

// File: rtl/s_mem_port_arbiter_rd_latency_ctr.sv
// Loadable down-counter with a zero flag; times the RAM read latency.
// Counts down by one per i_dec cycle and saturates at zero.
module rd_latency_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/s_mem_port_arbiter.sv
// Single-port S-memory arbiter for the RC4 init/shuffle/decrypt engines.
// Only the phase-active client is served; one access in flight at a time.
module s_mem_port_arbiter
  import s_mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                loop_1_done,
  input  logic                                loop_2_done,
  input  logic [NUM_CLIENTS-1:0]              req,
  input  logic [NUM_CLIENTS-1:0]              we,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_CLIENTS-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_CLIENTS-1:0]              gnt,
  output logic [NUM_CLIENTS-1:0]              rvalid,
  output logic [DATA_W-1:0]                   rdata,
  output logic [ADDR_W-1:0]                   mem_address,
  output logic [DATA_W-1:0]                   mem_data,
  output logic                                mem_wren,
  input  logic [DATA_W-1:0]                   mem_q
);

  localparam int CNT_W = 2;

  mem_port_state_t           r_state;
  client_id_t                r_tag;
  logic                      r_we;
  logic [NUM_CLIENTS-1:0]    r_gnt;
  logic [NUM_CLIENTS-1:0]    r_rvalid;
  logic [DATA_W-1:0]         r_rdata;
  logic [ADDR_W-1:0]         r_mem_address;
  logic [DATA_W-1:0]         r_mem_data;
  logic                      r_mem_wren;

  client_id_t                w_act;
  logic                      w_cnt_zero;

  // loop_2_done dominates so a simultaneous rise of both flags skips shuffle
  always_comb begin
    w_act = CLIENT_INIT;
    if (loop_2_done) begin
      w_act = CLIENT_DEC;
    end else if (loop_1_done) begin
      w_act = CLIENT_SHUF;
    end
  end

  rd_latency_ctr #(
    .CNT_W (CNT_W)
  ) u_rd_latency_ctr (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_load     (r_state == ISSUE),
    .i_load_val (CNT_W'(RD_LATENCY - 1)),
    .i_dec      (r_state == WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tag         <= CLIENT_INIT;
      r_we          <= 1'b0;
      r_gnt         <= '0;
      r_rvalid      <= '0;
      r_rdata       <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_mem_wren <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req[w_act]) begin
            r_state       <= ISSUE;
            r_tag         <= w_act;
            r_we          <= we[w_act];
            r_gnt         <= client_onehot(w_act);
            r_mem_address <= addr[w_act];
            r_mem_data    <= wdata[w_act];
            r_mem_wren    <= we[w_act];
          end
        end
        ISSUE: r_state <= r_we ? IDLE : WAIT;
        WAIT: begin
          // the latched tag, not the current phase, owns the response
          if (w_cnt_zero) begin
            r_rdata  <= mem_q;
            r_rvalid <= client_onehot(r_tag);
            r_state  <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_s_mem_port_arbiter.sv
// Directed bench: three arbiters (read latency 2, 1, 3) share one stimulus,
// each with its own RAM model whose unwritten contents are addr ^ 0x2C.
module tb_s_mem_port_arbiter;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             loop_1_done = 1'b0;
  logic             loop_2_done = 1'b0;
  logic [2:0]       req = '0;
  logic [2:0]       we = '0;
  logic [2:0][7:0]  addr = '0;
  logic [2:0][7:0]  wdata = '0;

  logic [2:0] gnt_a    [3];
  logic [2:0] rvalid_a [3];
  logic [7:0] rdata_a  [3];
  logic [7:0] maddr_a  [3];
  logic [7:0] mdata_a  [3];
  logic       wren_a   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [7:0]   ram [256];
    logic [255:0] wr_ok;
    logic [7:0]   q_pipe [3];
    logic [7:0]   mq;

    s_mem_port_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .RD_LATENCY (LAT)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .loop_1_done (loop_1_done),
      .loop_2_done (loop_2_done),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt_a[g]),
      .rvalid      (rvalid_a[g]),
      .rdata       (rdata_a[g]),
      .mem_address (maddr_a[g]),
      .mem_data    (mdata_a[g]),
      .mem_wren    (wren_a[g]),
      .mem_q       (mq)
    );

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ok <= '0;
      end else if (wren_a[g]) begin
        wr_ok[maddr_a[g]] <= 1'b1;
        ram[maddr_a[g]]   <= mdata_a[g];
      end
    end

    always @(posedge clk) begin
      q_pipe[0] <= wr_ok[maddr_a[g]] ? ram[maddr_a[g]] : (maddr_a[g] ^ 8'h2C);
      q_pipe[1] <= q_pipe[0];
      q_pipe[2] <= q_pipe[1];
    end

    assign mq = q_pipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " gnt"},    32'(gnt_a[0]),    32'h0);
    chk({tag, " rvalid"}, 32'(rvalid_a[0]), 32'h0);
    chk({tag, " wren"},   32'(wren_a[0]),   32'h0);
    chk({tag, " maddr"},  32'(maddr_a[0]),  32'h0);
    chk({tag, " mdata"},  32'(mdata_a[0]),  32'h0);
    chk({tag, " rdata"},  32'(rdata_a[0]),  32'h0);
  endtask

  // back-to-back client 2 reads against instance k with read latency lat
  task automatic rd_seq(input int k, input int lat);
    logic [7:0] addrs [3];
    int n;
    addrs[0] = 8'h01;
    addrs[1] = 8'h7E;
    addrs[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      req     = 3'b100;
      we      = 3'b000;
      addr[2] = addrs[i];
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt_a[k] == 3'b000 && n < 10);
      chk($sformatf("t6 L%0d gnt[%0d]", lat, i), 32'(gnt_a[k]), 32'b100);
      req = 3'b000;
      n = 0;
      do begin
        tick();
        n++;
      end while (rvalid_a[k] == 3'b000 && n < 8);
      chk($sformatf("t6 L%0d lat[%0d]", lat, i), 32'(n), 32'(lat + 1));
      chk($sformatf("t6 L%0d rvalid[%0d]", lat, i), 32'(rvalid_a[k]), 32'b100);
      chk($sformatf("t6 L%0d rdata[%0d]", lat, i), 32'(rdata_a[k]), 32'(addrs[i] ^ 8'h2C));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [2:0] rv_seen;

    // reset state, then reset in the middle of a read
    tick();
    tick();
    chk_zero_outs("rst");
    reset_n = 1'b1;
    tick();
    req = 3'b001; we = 3'b000; addr[0] = 8'h20; wdata[0] = 8'h77;
    tick();
    chk("t1 gnt", 32'(gnt_a[0]), 32'b001);
    chk("t1 maddr", 32'(maddr_a[0]), 32'h20);
    req = 3'b000;
    tick();
    reset_n = 1'b0;
    #1;
    chk_zero_outs("t1 midrst");
    tick();
    tick();
    reset_n = 1'b1;
    rv_seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      rv_seen |= rvalid_a[0];
    end
    chk("t1 no rvalid", 32'(rv_seen), 32'h0);

    // phase 0 write, req held through the gnt cycle
    req = 3'b001; we = 3'b001; addr[0] = 8'h05; wdata[0] = 8'hA5;
    tick();
    chk("t2 gnt", 32'(gnt_a[0]), 32'b001);
    chk("t2 wren", 32'(wren_a[0]), 32'h1);
    chk("t2 maddr", 32'(maddr_a[0]), 32'h05);
    chk("t2 mdata", 32'(mdata_a[0]), 32'hA5);
    tick();
    chk("t2 gnt off", 32'(gnt_a[0]), 32'h0);
    chk("t2 wren off", 32'(wren_a[0]), 32'h0);
    req = 3'b000; we = 3'b000;
    tick();
    chk("t2 no 2nd gnt", 32'(gnt_a[0]), 32'h0);
    chk("t2 no 2nd wren", 32'(wren_a[0]), 32'h0);
    chk("t2 maddr hold", 32'(maddr_a[0]), 32'h05);
    tick();

    // phase 1 read by client 1
    loop_1_done = 1'b1;
    req = 3'b010; addr[1] = 8'h10;
    tick();
    chk("t3 gnt", 32'(gnt_a[0]), 32'b010);
    chk("t3 wren", 32'(wren_a[0]), 32'h0);
    req = 3'b000;
    tick();
    chk("t3 rvalid T+2", 32'(rvalid_a[0]), 32'h0);
    tick();
    chk("t3 rvalid T+3", 32'(rvalid_a[0]), 32'h0);
    tick();
    chk("t3 rvalid", 32'(rvalid_a[0]), 32'b010);
    chk("t3 rdata", 32'(rdata_a[0]), 32'h3C);
    tick();
    chk("t3 rvalid off", 32'(rvalid_a[0]), 32'h0);
    chk("t3 rdata hold", 32'(rdata_a[0]), 32'h3C);
    tick();

    // non-active clients ignored until the phase moves on
    req = 3'b101; addr[0] = 8'h33; addr[2] = 8'h44;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t4 gnt %0d", i), 32'(gnt_a[0]), 32'h0);
      chk($sformatf("t4 wren %0d", i), 32'(wren_a[0]), 32'h0);
      chk($sformatf("t4 maddr %0d", i), 32'(maddr_a[0]), 32'h10);
    end
    loop_2_done = 1'b1;
    tick();
    chk("t4 gnt2", 32'(gnt_a[0]), 32'b100);
    chk("t4 maddr2", 32'(maddr_a[0]), 32'h44);
    req = 3'b000;
    tick();
    tick();
    tick();
    chk("t4 rvalid2", 32'(rvalid_a[0]), 32'b100);
    chk("t4 rdata2", 32'(rdata_a[0]), 32'h68);
    loop_2_done = 1'b0;
    tick();
    tick();

    // phase changes while client 1 read is in WAIT
    req = 3'b110; addr[1] = 8'hFF; addr[2] = 8'h80;
    tick();
    chk("t5 gnt1", 32'(gnt_a[0]), 32'b010);
    chk("t5 maddr", 32'(maddr_a[0]), 32'hFF);
    req = 3'b100;
    tick();
    loop_2_done = 1'b1;
    tick();
    chk("t5 gnt wait", 32'(gnt_a[0]), 32'h0);
    tick();
    chk("t5 rvalid1", 32'(rvalid_a[0]), 32'b010);
    chk("t5 rdata", 32'(rdata_a[0]), 32'hD3);
    chk("t5 gnt resp", 32'(gnt_a[0]), 32'h0);
    tick();
    chk("t5 gnt idle", 32'(gnt_a[0]), 32'h0);
    tick();
    chk("t5 gnt2", 32'(gnt_a[0]), 32'b100);
    chk("t5 maddr2", 32'(maddr_a[0]), 32'h80);
    req = 3'b000;
    tick();
    tick();
    tick();
    chk("t5 rvalid2", 32'(rvalid_a[0]), 32'b100);
    chk("t5 rdata2", 32'(rdata_a[0]), 32'hAC);

    // latency sweep on the L=1 and L=3 instances
    for (int i = 0; i < 10; i++) tick();
    rd_seq(1, 1);
    for (int i = 0; i < 10; i++) tick();
    rd_seq(2, 3);
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
